// File: rtl/fpgmips_pkg.sv
// rtl/fpgmips_pkg.sv - shared opcodes, ALU select codes, FSM states and instruction layout
package fpgmips_pkg;

  localparam logic [5:0] OP_MOV  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BLT  = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_SUB  = 3'b010;
  localparam logic [2:0] SEL_MUL  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] low;
  } instr_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       legal;
    logic       writes;
    logic       is_beq;
    logic       is_blt;
    logic       is_halt;
    logic       long_exec;
  } op_info_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake, register-file and ALU control bundle
interface alu_sequencer_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [4:0]  reg_read_a;
  logic [4:0]  reg_read_b;
  logic [2:0]  alu_selection;
  logic        alu_is_zero;
  logic        alu_is_negative;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic        branch_taken;
  logic        illegal_op;
  logic        halted;

  modport master (
    input  instr_valid, instruction, alu_is_zero, alu_is_negative,
    output instr_ready, reg_read_a, reg_read_b, alu_selection,
           reg_write_enable, reg_write_address, branch_taken, illegal_op, halted
  );

  modport slave (
    output instr_valid, instruction, alu_is_zero, alu_is_negative,
    input  instr_ready, reg_read_a, reg_read_b, alu_selection,
           reg_write_enable, reg_write_address, branch_taken, illegal_op, halted
  );

endinterface

// File: rtl/op_decoder.sv
// rtl/op_decoder.sv - combinational opcode legality and ALU select decode
// MUL is legal (two-cycle execute) only when ALU_SEQUENCER_MUL_EN is defined.
module op_decoder
  import fpgmips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_info_t   info_o
);

  always_comb begin
    info_o = '0;
    case (opcode_i)
      OP_MOV: begin
        info_o.legal  = 1'b1;
        info_o.writes = 1'b1;
        info_o.sel    = SEL_PASS;
      end
      OP_ADD: begin
        info_o.legal  = 1'b1;
        info_o.writes = 1'b1;
        info_o.sel    = SEL_ADD;
      end
      OP_SUB: begin
        info_o.legal  = 1'b1;
        info_o.writes = 1'b1;
        info_o.sel    = SEL_SUB;
      end
`ifdef ALU_SEQUENCER_MUL_EN
      OP_MUL: begin
        info_o.legal     = 1'b1;
        info_o.writes    = 1'b1;
        info_o.sel       = SEL_MUL;
        info_o.long_exec = 1'b1;
      end
`endif
      OP_BEQ: begin
        info_o.legal  = 1'b1;
        info_o.is_beq = 1'b1;
        info_o.sel    = SEL_SUB;
      end
      OP_BLT: begin
        info_o.legal  = 1'b1;
        info_o.is_blt = 1'b1;
        info_o.sel    = SEL_SUB;
      end
      OP_HALT: begin
        info_o.legal   = 1'b1;
        info_o.is_halt = 1'b1;
      end
      default: info_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - IDLE/DECODE/EXECUTE/WRITEBACK/HALTED instruction sequencer
// ALU_SEQUENCER_MUL_EN (in op_decoder) enables MUL with a two-cycle EXECUTE.
module alu_sequencer
  import fpgmips_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  alu_sequencer_if.master bus
);

  state_t   state_q, state_d;
  instr_t   instr_q, instr_d;
  logic     zero_q, zero_d;
  logic     neg_q, neg_d;
  logic     exec_cnt_q, exec_cnt_d;
  logic     exec_last;
  op_info_t info;
  logic     unused_low;

  op_decoder u_op_decoder (
    .opcode_i (instr_q.opcode),
    .info_o   (info)
  );

  // Long-execute ops spend one extra EXECUTE cycle before the flags are taken.
  assign exec_last  = !(info.long_exec && !exec_cnt_q);
  assign unused_low = ^instr_q.low;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      exec_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    exec_cnt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = instr_t'(bus.instruction);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = info.is_halt ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (exec_last) begin
          zero_d  = bus.alu_is_zero;
          neg_d   = bus.alu_is_negative;
          state_d = ST_WRITEBACK;
        end else begin
          exec_cnt_d = 1'b1;
        end
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready       = 1'b0;
    bus.reg_read_a        = '0;
    bus.reg_read_b        = '0;
    bus.alu_selection     = SEL_PASS;
    bus.reg_write_enable  = 1'b0;
    bus.reg_write_address = '0;
    bus.branch_taken      = 1'b0;
    bus.illegal_op        = 1'b0;
    bus.halted            = 1'b0;
    case (state_q)
      // Held low while reset is asserted so every output reads zero.
      ST_IDLE: bus.instr_ready = !reset;
      ST_DECODE: begin
        bus.reg_read_a = instr_q.rs;
        bus.reg_read_b = instr_q.rt;
      end
      ST_EXECUTE: begin
        bus.reg_read_a    = instr_q.rs;
        bus.reg_read_b    = instr_q.rt;
        bus.alu_selection = info.sel;
      end
      ST_WRITEBACK: begin
        bus.reg_read_a = instr_q.rs;
        bus.reg_read_b = instr_q.rt;
        if (!info.legal) begin
          bus.illegal_op = 1'b1;
        end else if (info.writes) begin
          bus.reg_write_enable  = 1'b1;
          bus.reg_write_address = instr_q.rd;
        end else begin
          bus.branch_taken = (info.is_beq && zero_q) || (info.is_blt && neg_q);
        end
      end
      ST_HALTED: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - table-driven, scoreboarded bench for alu_sequencer
module tb_alu_sequencer;

  logic clock = 1'b0;
  logic reset;

  alu_sequencer_if bus();

  alu_sequencer u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       zero;
    logic       neg;
    logic [2:0] sel;
    int         wb;
    logic       we;
    logic       bt;
    logic       ill;
  } vec_t;

  typedef struct {
    string      name;
    logic       we;
    logic [4:0] wa;
    logic       bt;
    logic       ill;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    logic [10:0] low;
    low = 11'($urandom);
    return {op, rs, rt, rd, low};
  endfunction

  function automatic logic [22:0] all_out();
    return {bus.instr_ready, bus.reg_read_a, bus.reg_read_b, bus.alu_selection,
            bus.reg_write_enable, bus.reg_write_address, bus.branch_taken,
            bus.illegal_op, bus.halted};
  endfunction

  function automatic vec_t mkv(input string n, input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic z,
                               input logic ng, input logic [2:0] sel, input int wb,
                               input logic we, input logic bt, input logic ill);
    vec_t v;
    v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
    v.zero = z; v.neg = ng; v.sel = sel; v.wb = wb;
    v.we = we; v.bt = bt; v.ill = ill;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run_vec(input vec_t v);
    exp_t e;
    logic in_exec;
    bus.instr_valid = 1'b1;
    bus.instruction = mk(v.op, v.rs, v.rt, v.rd);
    e.name = v.name;
    e.we   = v.we;
    e.wa   = v.we ? v.rd : 5'd0;
    e.bt   = v.bt;
    e.ill  = v.ill;
    sb_q.push_back(e);
    for (int c = 1; c <= v.wb + 1; c++) begin
      @(posedge clock);
      #1;
      bus.instr_valid     = (c <= v.wb);
      bus.instruction     = $urandom;
      in_exec             = (c >= 2) && (c < v.wb);
      bus.alu_is_zero     = in_exec ? v.zero : ~v.zero;
      bus.alu_is_negative = in_exec ? v.neg : ~v.neg;
      @(negedge clock);
      check($sformatf("%s_c%0d_sel", v.name, c), 32'(bus.alu_selection),
            32'(in_exec ? v.sel : 3'd0));
      check($sformatf("%s_c%0d_ready", v.name, c), 32'(bus.instr_ready),
            32'(c == v.wb + 1));
      if (c <= v.wb) begin
        check($sformatf("%s_c%0d_rd_addr", v.name, c),
              32'({bus.reg_read_a, bus.reg_read_b}), 32'({v.rs, v.rt}));
      end
      if (c == v.wb) begin
        e = sb_q.pop_front();
        check($sformatf("%s_wb_we", e.name), 32'(bus.reg_write_enable), 32'(e.we));
        check($sformatf("%s_wb_wa", e.name), 32'(bus.reg_write_address), 32'(e.wa));
        check($sformatf("%s_wb_bt", e.name), 32'(bus.branch_taken), 32'(e.bt));
        check($sformatf("%s_wb_ill", e.name), 32'(bus.illegal_op), 32'(e.ill));
      end else begin
        check($sformatf("%s_c%0d_no_strobe", v.name, c),
              32'({bus.reg_write_enable, bus.branch_taken, bus.illegal_op}), 32'(0));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.instr_valid     = 1'b0;
    bus.instruction     = '0;
    bus.alu_is_zero     = 1'b0;
    bus.alu_is_negative = 1'b0;
    reset               = 1'b1;

    vecs.push_back(mkv("add_rd5",  6'b000001, 5'd3,  5'd4,  5'd5,  1'b0, 1'b0, 3'b001, 3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkv("beq_z1",   6'b000100, 5'd1,  5'd2,  5'd7,  1'b1, 1'b0, 3'b010, 3, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkv("beq_z0",   6'b000100, 5'd1,  5'd1,  5'd7,  1'b0, 1'b1, 3'b010, 3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv("blt_n1",   6'b000101, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1, 3'b010, 3, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkv("blt_n0",   6'b000101, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 3'b010, 3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv("ill_15",   6'b010101, 5'd6,  5'd9,  5'd13, 1'b1, 1'b1, 3'b000, 3, 1'b0, 1'b0, 1'b1));
`ifdef ALU_SEQUENCER_MUL_EN
    vecs.push_back(mkv("mul_on",   6'b000011, 5'd14, 5'd15, 5'd17, 1'b0, 1'b0, 3'b101, 4, 1'b1, 1'b0, 1'b0));
`else
    vecs.push_back(mkv("mul_off",  6'b000011, 5'd14, 5'd15, 5'd17, 1'b0, 1'b0, 3'b000, 3, 1'b0, 1'b0, 1'b1));
`endif
    vecs.push_back(mkv("mov_rd31", 6'b000000, 5'd31, 5'd0,  5'd31, 1'b0, 1'b0, 3'b000, 3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkv("sub_rd0",  6'b000010, 5'd2,  5'd3,  5'd0,  1'b1, 1'b1, 3'b010, 3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkv("ill_20",   6'b100000, 5'd8,  5'd16, 5'd24, 1'b0, 1'b0, 3'b000, 3, 1'b0, 1'b0, 1'b1));

    repeat (2) @(negedge clock);
    check("reset_outputs", 32'(all_out()), 32'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(all_out()), 32'(23'h400000));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // HALT, then keep offering ADDs that must never be accepted.
    bus.instr_valid = 1'b1;
    bus.instruction = mk(6'b111111, 5'd1, 5'd2, 5'd3);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clock);
      #1 bus.instruction = mk(6'b000001, 5'd4, 5'd5, 5'd6);
      @(negedge clock);
      check($sformatf("halt_c%0d_halted", c), 32'(bus.halted), 32'(c >= 2));
      check($sformatf("halt_c%0d_ready", c),
            32'({bus.instr_ready, bus.reg_write_enable, bus.alu_selection}), 32'(0));
    end
    #2 reset = 1'b1;
    #1 check("halt_reset_outputs", 32'(all_out()), 32'(0));
    @(posedge clock);
    #1;
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clock);
    check("halt_exit_ready", 32'(all_out()), 32'(23'h400000));

    // Reset in the middle of EXECUTE for a SUB.
    bus.instr_valid = 1'b1;
    bus.instruction = mk(6'b000010, 5'd7, 5'd8, 5'd9);
    @(posedge clock);
    #1 bus.instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("sub_exec_sel", 32'(bus.alu_selection), 32'(3'b010));
    #1 reset = 1'b1;
    #1 check("sub_reset_outputs", 32'(all_out()), 32'(0));
    @(posedge clock);
    #1 check("sub_reset_held", 32'(all_out()), 32'(0));
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      check($sformatf("sub_after_reset_c%0d", c), 32'(all_out()), 32'(23'h400000));
    end

    run_vec(mkv("add_post", 6'b000001, 5'd30, 5'd29, 5'd28, 1'b0, 1'b0, 3'b001, 3, 1'b1, 1'b0, 1'b0));

    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock and reset ports are named clock and reset.
REQ-002 The ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instruction  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd
- reg_read_a  out  5  register-file read address A (rs)
- reg_read_b  out  5  register-file read address B (rt)
- alu_selection  out  3  ALU operation select
- alu_is_zero  in  1  ALU zero flag
- alu_is_negative  in  1  ALU sign flag
- reg_write_enable  out  1  one-cycle write strobe
- reg_write_address  out  5  write destination (rd)
- branch_taken  out  1  one-cycle branch-decision strobe
- illegal_op  out  1  one-cycle unknown-opcode strobe
- halted  out  1  sequencer stopped

Function
REQ-003 Opcodes SHALL be: MOV 000000 (sel 000), ADD 000001 (sel 001), SUB 000010 (sel 010), MUL 000011 (sel 101), BEQ 000100 (sel 010), BLT 000101 (sel 010), HALT 111111; all others are illegal.
REQ-004 States SHALL be IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
REQ-005 IDLE: instr_ready=1; on instr_valid&instr_ready the instruction is latched and the state moves to DECODE; otherwise the state holds.
REQ-006 instr_ready SHALL be 0 in every state except IDLE; instruction changes outside IDLE are ignored.
REQ-007 DECODE: reg_read_a=rs and reg_read_b=rt from the latched word, held through WRITEBACK; HALT goes to HALTED, all other opcodes go to EXECUTE.
REQ-008 EXECUTE: alu_selection driven per REQ-003; flags sampled on the last EXECUTE cycle into internal registers; then WRITEBACK.
REQ-009 alu_selection SHALL be 000 in every state other than EXECUTE.
REQ-010 WRITEBACK (one cycle, then IDLE):
- MOV/ADD/SUB/MUL: reg_write_enable=1, reg_write_address=rd.
- BEQ: branch_taken=sampled zero.
- BLT: branch_taken=sampled negative.
- Illegal opcode: illegal_op=1, no write, no branch.
REQ-011 Latency SHALL be handshake at cycle 0, DECODE at cycle 1, EXECUTE at cycle 2, WRITEBACK at cycle 3, next accept possible at cycle 4.
REQ-012 Strobes SHALL be mutually exclusive and 0 outside WRITEBACK.
REQ-013 HALTED SHALL be absorbing: halted=1, instr_ready=0, and only reset exits it.

Reset
REQ-014 Reset SHALL force IDLE immediately, abandon any in-flight instruction without strobes, and clear latched instruction, flags, all strobes, alu_selection, reg_read_a/b, reg_write_address and halted to 0.
REQ-015 The first cycle after reset deassertion SHALL show instr_ready=1.

Configuration
REQ-016 With macro ALU_SEQUENCER_MUL_EN defined, MUL SHALL be legal and EXECUTE lasts two cycles with sel 101 held, so WRITEBACK is at cycle 4.
REQ-017 Without ALU_SEQUENCER_MUL_EN, opcode 000011 SHALL be illegal (illegal_op strobe, sel 000 throughout).

Structure
REQ-018 Opcode constants, ALU selection codes and state encodings SHALL live in a shared package fpgmips_pkg, which the ALU also uses.
REQ-019 Opcode-to-selection and legality decoding SHALL be a combinational sub-module op_decoder; the FSM stays in alu_sequencer.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD rd=5 accepted at cycle 0 -> sel 001 at cycle 2; reg_write_enable=1, reg_write_address=5 at cycle 3; instr_ready=1 at cycle 4.
- BEQ with alu_is_zero=1 in EXECUTE -> branch_taken=1 at cycle 3; repeat with 0 -> branch_taken=0; BLT with alu_is_negative=1 -> branch_taken=1.
- Opcode 010101 -> illegal_op=1 at cycle 3, reg_write_enable=0; MUL with macro off -> illegal_op=1; MUL with macro on -> sel 101 at cycles 2-3, write at cycle 4.
- HALT -> halted=1 from cycle 2; instr_valid held high for 20 cycles -> no accept; reset -> IDLE.
- Reset asserted mid-EXECUTE of SUB -> all outputs 0 immediately, no strobe; after release, instr_ready=1 on the first cycle.
